four_bit_divider: RTL

FOUR_BIT_DIVIDER -- requirements
Module: four_bit_divider

---
 rtl/four_bit_divider_pkg.sv | 16 +
 rtl/four_bit_divider_full_sub.sv | 21 ++
 rtl/four_bit_divider.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/four_bit_divider_pkg.sv
// -----------------------------------------------------------------------------
// four_bit_divider_pkg
// Shared definitions for the restoring divider: the FSM state encoding and the
// default operand width.
// -----------------------------------------------------------------------------
package four_bit_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/four_bit_divider_full_sub.sv
// -----------------------------------------------------------------------------
// full_sub
// One-bit full subtractor: computes a - b - borrow_in.
// Ports:
//   a, b       : minuend / subtrahend bits
//   borrow_in  : borrow from the next less significant stage
//   diff       : difference bit
//   borrow_out : borrow into the next more significant stage
// -----------------------------------------------------------------------------
module full_sub (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/four_bit_divider.sv
// -----------------------------------------------------------------------------
// four_bit_divider
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// Ports:
//   clk         : rising-edge clock
//   rst_n       : synchronous active-low reset
//   start       : request a division (ignored while busy or in reset)
//   a, b        : dividend / divisor, captured when start is accepted
//   busy        : high while the divider is iterating (CALC)
//   done        : one-cycle pulse when q, r and div_by_zero are fresh
//   q, r        : quotient / remainder, held between results
//   div_by_zero : last accepted division had b == 0
// -----------------------------------------------------------------------------
module four_bit_divider
    import four_bit_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-2:0] quot;
    logic [CW-1:0]    count;

    logic             last_calc;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] borrow;
    logic             trial_neg;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_shift;

    // When the trial difference is kept it is smaller than the divisor, so
    // its top bit is always zero and is deliberately dropped.
    logic             unused_diff_msb;
    assign unused_diff_msb = diff[WIDTH];

    assign last_calc = (count == CW'(WIDTH - 1));

    // Bring the next dividend bit into the partial remainder.
    assign shifted = {rem, dividend[WIDTH-1]};
    assign sub_b   = {1'b0, divisor};

    // Ripple-borrow trial subtraction, WIDTH+1 bits wide.
    assign borrow[0] = 1'b0;
    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        full_sub u_full_sub (
            .a          (shifted[i]),
            .b          (sub_b[i]),
            .borrow_in  (borrow[i]),
            .diff       (diff[i]),
            .borrow_out (borrow[i+1])
        );
    end

    // A final borrow means the trial went negative: restore the shifted value.
    assign trial_neg  = borrow[WIDTH+1];
    assign rem_next   = trial_neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_shift = {quot, ~trial_neg};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the state-decoded busy/done strobes. A start in
    // FIN is accepted while done still flags the result that is completing.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (b == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_calc) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done = 1'b1;
                if (start) begin
                    state_next = (b == '0) ? FIN : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Visible results only change on the edge that enters FIN, so
    // intermediate iteration values never reach q or r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dividend    <= '0;
            divisor     <= '0;
            rem         <= '0;
            quot        <= '0;
            count       <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        if (b != '0) begin
                            dividend <= a;
                            divisor  <= b;
                            rem      <= '0;
                            quot     <= '0;
                            count    <= '0;
                        end else begin
                            q           <= '1;
                            r           <= a;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dividend <= {dividend[WIDTH-2:0], 1'b0};
                    rem      <= rem_next;
                    quot     <= quot_shift[WIDTH-2:0];
                    count    <= count + CW'(1);
                    if (last_calc) begin
                        q           <= quot_shift;
                        r           <= rem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
